// File: rtl/ctrl_pipe_pkg.sv
// Shared control-bundle definitions for the ID/EX .. MEM/WB control pipeline.
// Bit map of the decoded control word and the all-zero bubble encoding.
package ctrl_pipe_pkg;

  localparam int unsigned CTRL_W = 10;

  localparam int unsigned REGDST   = 0;
  localparam int unsigned ALUSRC   = 1;
  localparam int unsigned MEMTOREG = 2;
  localparam int unsigned REGWRITE = 3;
  localparam int unsigned MEMREAD  = 4;
  localparam int unsigned MEMWRITE = 5;
  localparam int unsigned BRANCH   = 6;
  localparam int unsigned JRCTRL   = 7;
  localparam int unsigned ALUOP_LO = 8;
  localparam int unsigned ALUOP_HI = 9;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage of the control bundle: loads either the incoming bundle or a bubble
// (all-zero control, valid low). Asynchronous active-high reset.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned W = CTRL_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_bubble,
  input  logic [W-1:0] i_ctrl,
  input  logic         i_valid,
  output logic [W-1:0] o_ctrl,
  output logic         o_valid
);

  logic [W-1:0] r_ctrl;
  logic         r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else if (i_bubble) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_ctrl  <= i_ctrl;
      r_valid <= i_valid;
    end
  end

  assign o_ctrl  = r_ctrl;
  assign o_valid = r_valid;

endmodule

// File: rtl/ctrl_pipe_flush.sv
// Control-bundle pipeline with stall bubbles, flush squash plus hold window, and a
// saturating bubble counter for performance debug.
module ctrl_pipe_flush #(
  parameter int unsigned CTRL_W      = ctrl_pipe_pkg::CTRL_W,
  parameter int unsigned STAGES      = 3,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned FLUSH_HOLD  = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic                     valid_in,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     bubble_clr,
  output logic [STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [STAGES-1:0]        stage_valid,
  output logic                     flush_busy,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam int unsigned HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD + 1) : 1;

  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_d;
  logic              r_flush_busy;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  w_bubble_d;
  logic              w_kill;
  logic              w_bub0;
  logic              w_count;

  logic [CTRL_W-1:0] w_ctrl [STAGES];
  logic [STAGES-1:0] w_valid;

  assign w_kill  = flush | (r_hold_cnt != '0);
  assign w_count = w_kill | stall;
  assign w_bub0  = w_count | ~valid_in;

  always_comb begin
    w_hold_d = r_hold_cnt;
    if (flush) begin
      w_hold_d = HOLD_W'(FLUSH_HOLD - 1);
    end else if (r_hold_cnt != '0) begin
      w_hold_d = r_hold_cnt - 1'b1;
    end
  end

  always_comb begin
    w_bubble_d = r_bubble_cnt;
    if (bubble_clr) begin
      w_bubble_d = '0;
    end else if (w_count && (r_bubble_cnt != '1)) begin
      w_bubble_d = r_bubble_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt   <= '0;
      r_flush_busy <= 1'b0;
      r_bubble_cnt <= '0;
    end else begin
      r_hold_cnt   <= w_hold_d;
      // Registered copy of the next hold count keeps flush_busy free of input paths.
      r_flush_busy <= (w_hold_d != '0);
      r_bubble_cnt <= w_bubble_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      ctrl_stage_reg #(
        .W (CTRL_W)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (w_bub0),
        .i_ctrl   (ctrl_in),
        .i_valid  (1'b1),
        .o_ctrl   (w_ctrl[k]),
        .o_valid  (w_valid[k])
      );
    end else begin : g_rest
      localparam bit SQUASH = (k - 1) < int'(FLUSH_DEPTH);
      ctrl_stage_reg #(
        .W (CTRL_W)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (flush & SQUASH),
        .i_ctrl   (w_ctrl[k-1]),
        .i_valid  (w_valid[k-1]),
        .o_ctrl   (w_ctrl[k]),
        .o_valid  (w_valid[k])
      );
    end
    assign stage_ctrl[k*CTRL_W +: CTRL_W] = w_ctrl[k];
  end

  assign stage_valid = w_valid;
  assign flush_busy  = r_flush_busy;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_ctrl_pipe_flush.sv
// Self-checking bench for ctrl_pipe_flush: directed scenarios plus random traffic,
// compared each cycle against a behavioural model of the stage contents.
module tb_ctrl_pipe_flush;

  localparam int CW   = 10;
  localparam int ST   = 3;
  localparam int FD   = 1;
  localparam int FH   = 2;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [CW-1:0]       ctrl_in = '0;
  logic                valid_in = 1'b0;
  logic                stall = 1'b0;
  logic                flush = 1'b0;
  logic                bubble_clr = 1'b0;
  logic [ST*CW-1:0]    stage_ctrl;
  logic [ST-1:0]       stage_valid;
  logic                flush_busy;
  logic [CNTW-1:0]     bubble_cnt;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] m_ctrl [ST];
  logic          m_valid [ST];
  int            m_hold;
  int            m_bcnt;
  int            base_cnt;

  ctrl_pipe_flush #(
    .CTRL_W      (CW),
    .STAGES      (ST),
    .FLUSH_DEPTH (FD),
    .FLUSH_HOLD  (FH),
    .CNT_W       (CNTW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl_in     (ctrl_in),
    .valid_in    (valid_in),
    .stall       (stall),
    .flush       (flush),
    .bubble_clr  (bubble_clr),
    .stage_ctrl  (stage_ctrl),
    .stage_valid (stage_valid),
    .flush_busy  (flush_busy),
    .bubble_cnt  (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ST; i++) begin
      m_ctrl[i]  = '0;
      m_valid[i] = 1'b0;
    end
    m_hold = 0;
    m_bcnt = 0;
  endtask

  // One clock edge of the pipeline, described as "shift everything, then overwrite bubbles".
  task automatic model_edge();
    bit kill;
    kill = flush || (m_hold > 0);
    for (int k = ST - 1; k >= 1; k--) begin
      if (flush && (k - 1 < FD)) begin
        m_ctrl[k] = '0; m_valid[k] = 1'b0;
      end else begin
        m_ctrl[k] = m_ctrl[k-1]; m_valid[k] = m_valid[k-1];
      end
    end
    if (kill || stall || !valid_in) begin
      m_ctrl[0] = '0; m_valid[0] = 1'b0;
    end else begin
      m_ctrl[0] = ctrl_in; m_valid[0] = 1'b1;
    end
    if (flush) m_hold = FH - 1;
    else if (m_hold > 0) m_hold--;
    if (bubble_clr) m_bcnt = 0;
    else if ((kill || stall) && m_bcnt < CMAX) m_bcnt++;
  endtask

  task automatic check_all(input string tag);
    logic [ST*CW-1:0] ec;
    logic [ST-1:0]    ev;
    for (int k = 0; k < ST; k++) begin
      ec[k*CW +: CW] = m_ctrl[k];
      ev[k]          = m_valid[k];
    end
    chk({tag, ".ctrl"}, 32'(stage_ctrl), 32'(ec));
    chk({tag, ".valid"}, 32'(stage_valid), 32'(ev));
    chk({tag, ".busy"}, 32'(flush_busy), 32'(m_hold > 0));
    chk({tag, ".bcnt"}, 32'(bubble_cnt), 32'(m_bcnt));
  endtask

  task automatic step(input string tag, input logic [CW-1:0] c, input logic v,
                      input logic s, input logic f, input logic clr);
    ctrl_in = c; valid_in = v; stall = s; flush = f; bubble_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12 reset = 1'b0;
    check_all("reset");

    // Single instruction walks the pipe.
    step("t2e1", 10'h2A5, 1, 0, 0, 0);
    chk("t2.s0", 32'(stage_ctrl[0 +: CW]), 32'h2A5);
    step("t2e2", 10'h000, 0, 0, 0, 0);
    chk("t2.s1", 32'(stage_ctrl[CW +: CW]), 32'h2A5);
    step("t2e3", 10'h000, 0, 0, 0, 0);
    chk("t2.s2", 32'(stage_ctrl[2*CW +: CW]), 32'h2A5);
    chk("t2.v", 32'(stage_valid), 32'b100);

    // Stall bubble.
    step("t3a", 10'h155, 1, 0, 0, 0);
    step("t3b", 10'h3FF, 1, 1, 0, 0);
    chk("t3.s0v", 32'(stage_valid[0]), 32'd0);
    chk("t3.s1", 32'(stage_ctrl[CW +: CW]), 32'h155);
    chk("t3.cnt", 32'(bubble_cnt), 32'd1);

    // Flush with hold window of two cycles.
    step("t4b", 10'h0BB, 1, 0, 0, 0);
    step("t4a", 10'h0AA, 1, 0, 0, 0);
    base_cnt = m_bcnt;
    step("t4e1", 10'h123, 1, 0, 1, 0);
    chk("t4.s2", 32'(stage_ctrl[2*CW +: CW]), 32'h0BB);
    chk("t4.busy", 32'(flush_busy), 32'd1);
    step("t4e2", 10'h123, 1, 0, 0, 0);
    chk("t4.s0v", 32'(stage_valid[0]), 32'd0);
    step("t4e3", 10'h123, 1, 0, 0, 0);
    chk("t4.s0", 32'(stage_ctrl[0 +: CW]), 32'h123);
    chk("t4.cnt", 32'(bubble_cnt), 32'(base_cnt + 2));

    // Flush with stall, then re-flush while busy.
    step("t5a", 10'h011, 1, 0, 0, 0);
    step("t5b", 10'h022, 1, 1, 1, 0);
    step("t5c", 10'h033, 1, 0, 1, 0);
    step("t5d", 10'h044, 1, 0, 0, 0);
    chk("t5.hold", 32'(stage_valid[0]), 32'd0);
    step("t5e", 10'h055, 1, 0, 0, 0);
    chk("t5.resume", 32'(stage_ctrl[0 +: CW]), 32'h055);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rnd", CW'($urandom_range(0, 1023)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset mid-operation.
    step("prerst1", 10'h1C3, 1, 0, 0, 0);
    step("prerst2", 10'h0F0, 1, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    #3 reset = 1'b0;

    // Saturation and clear priority.
    step("t6clr", 10'h000, 1, 0, 0, 1);
    for (int i = 0; i < 20; i++) step("t6st", 10'h3FF, 1, 1, 0, 0);
    chk("t6.sat", 32'(bubble_cnt), 32'd15);
    step("t6clr2", 10'h3FF, 1, 1, 0, 1);
    chk("t6.clr", 32'(bubble_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
